// File: rtl/dca_seq_pkg.sv
// Shared definitions for the block-step sequencer: FSM encoding, command layout
// and default field widths.
package dca_seq_pkg;

    localparam int BW_IDX_DEF  = 8;
    localparam int BW_INFO_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Command word layout as stored in the FIFO (MSB first), at default widths.
    typedef struct packed {
        logic [BW_INFO_DEF-1:0] info;
        logic [BW_IDX_DEF-1:0]  num_k;
        logic [BW_IDX_DEF-1:0]  num_col;
        logic [BW_IDX_DEF-1:0]  num_row;
    } cmd_t;

endpackage

// File: rtl/dca_cmd_fifo.sv
// Small synchronous command FIFO with registered pointers; flags derive only from
// registered state so a push is never visible to the reader in the same cycle.
module dca_cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/dca_block_step_sequencer.sv
// Expands buffered tiled-matrix commands into block steps, walking k innermost,
// then column, then row, over a valid/ready handshake.
module dca_block_step_sequencer
    import dca_seq_pkg::*;
#(
    parameter int BW_IDX    = BW_IDX_DEF,
    parameter int BW_INFO   = BW_INFO_DEF,
    parameter int CMD_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [BW_IDX-1:0]  cmd_num_row,
    input  logic [BW_IDX-1:0]  cmd_num_col,
    input  logic [BW_IDX-1:0]  cmd_num_k,
    input  logic [BW_INFO-1:0] cmd_info,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [BW_IDX-1:0]  step_row,
    output logic [BW_IDX-1:0]  step_col,
    output logic [BW_IDX-1:0]  step_k,
    output logic               step_first_k,
    output logic               step_last_k,
    output logic               step_last,
    output logic [BW_INFO-1:0] step_info,
    output logic               busy,
    output logic               done
);

    localparam int CW = 3 * BW_IDX + BW_INFO;
    localparam logic [BW_IDX-1:0] IDX_ONE = BW_IDX'(1);

    seq_state_e         state_reg, state_next;
    logic [BW_IDX-1:0]  num_row_reg, num_row_next;
    logic [BW_IDX-1:0]  num_col_reg, num_col_next;
    logic [BW_IDX-1:0]  num_k_reg, num_k_next;
    logic [BW_IDX-1:0]  row_reg, row_next;
    logic [BW_IDX-1:0]  col_reg, col_next;
    logic [BW_IDX-1:0]  k_reg, k_next;
    logic [BW_INFO-1:0] info_reg, info_next;
    logic               done_reg, done_next;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]      fifo_dout;
    logic [BW_IDX-1:0]  pop_row, pop_col, pop_k;
    logic [BW_INFO-1:0] pop_info;
    logic               run, k_wrap, col_wrap, row_wrap;

    assign cmd_ready = ~fifo_full & ~clear;

    dca_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (cmd_valid & cmd_ready),
        .push_data ({cmd_info, cmd_num_k, cmd_num_col, cmd_num_row}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {pop_info, pop_k, pop_col, pop_row} = fifo_dout;

    assign run      = (state_reg == ST_RUN);
    assign k_wrap   = (k_reg == num_k_reg - IDX_ONE);
    assign col_wrap = (col_reg == num_col_reg - IDX_ONE);
    assign row_wrap = (row_reg == num_row_reg - IDX_ONE);

    // Flags are gated by run so every output idles at 0 after reset.
    assign step_valid   = run;
    assign step_row     = row_reg;
    assign step_col     = col_reg;
    assign step_k       = k_reg;
    assign step_first_k = run & (k_reg == '0);
    assign step_last_k  = run & k_wrap;
    assign step_last    = run & k_wrap & col_wrap & row_wrap;
    assign step_info    = info_reg;
    assign busy         = run | ~fifo_empty;
    assign done         = done_reg;

    always_comb begin
        state_next   = state_reg;
        num_row_next = num_row_reg;
        num_col_next = num_col_reg;
        num_k_next   = num_k_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        k_next       = k_reg;
        info_next    = info_reg;
        done_next    = 1'b0;
        fifo_pop     = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        num_row_next = pop_row;
                        num_col_next = pop_col;
                        num_k_next   = pop_k;
                        info_next    = pop_info;
                        row_next     = '0;
                        col_next     = '0;
                        k_next       = '0;
                        // A degenerate command completes immediately with no steps.
                        if (pop_row == '0 || pop_col == '0 || pop_k == '0) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (step_ready) begin
                        if (step_last) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else if (!k_wrap) begin
                            k_next = k_reg + IDX_ONE;
                        end else if (!col_wrap) begin
                            k_next   = '0;
                            col_next = col_reg + IDX_ONE;
                        end else begin
                            k_next   = '0;
                            col_next = '0;
                            row_next = row_reg + IDX_ONE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            num_row_reg <= '0;
            num_col_reg <= '0;
            num_k_reg   <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            k_reg       <= '0;
            info_reg    <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            num_row_reg <= num_row_next;
            num_col_reg <= num_col_next;
            num_k_reg   <= num_k_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            k_reg       <= k_next;
            info_reg    <= info_next;
            done_reg    <= done_next;
        end
    end

endmodule

// File: tb/tb_dca_block_step_sequencer.sv
// Self-checking bench: a queue of expected steps is generated from every accepted
// command by nested loops and compared against each offered step.
module tb_dca_block_step_sequencer;

    logic        clk = 1'b0;
    logic        rst, clear, cmd_valid, cmd_ready, step_valid, step_ready;
    logic [7:0]  cmd_num_row, cmd_num_col, cmd_num_k;
    logic [15:0] cmd_info;
    logic [7:0]  step_row, step_col, step_k;
    logic        step_first_k, step_last_k, step_last, busy, done;
    logic [15:0] step_info;

    int          n_cmp = 0;
    int          n_err = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          acc_cnt = 0;
    logic        done_due = 1'b0;
    logic [42:0] exp_q[$];

    always #5 clk = ~clk;

    dca_block_step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_num_row  (cmd_num_row),
        .cmd_num_col  (cmd_num_col),
        .cmd_num_k    (cmd_num_k),
        .cmd_info     (cmd_info),
        .step_valid   (step_valid),
        .step_ready   (step_ready),
        .step_row     (step_row),
        .step_col     (step_col),
        .step_k       (step_k),
        .step_first_k (step_first_k),
        .step_last_k  (step_last_k),
        .step_last    (step_last),
        .step_info    (step_info),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int nr, input int nc, input int nk, input logic [15:0] inf);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                for (int k = 0; k < nk; k++)
                    exp_q.push_back({inf, 8'(r), 8'(c), 8'(k), k == 0, k == nk - 1,
                                     (r == nr - 1) && (c == nc - 1) && (k == nk - 1)});
    endtask

    // One clock: observe at negedge, apply model updates, return 1 time unit after posedge.
    task automatic cycle();
        logic due_n;
        due_n = 1'b0;
        @(negedge clk);
        if (done_due) chk("done_after_last", {63'd0, done}, 64'd1);
        if (done) done_cnt++;
        if (step_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_step", {63'd0, step_valid}, 64'd0);
            end else begin
                chk("step_payload", {21'd0, step_info, step_row, step_col, step_k,
                                     step_first_k, step_last_k, step_last}, {21'd0, exp_q[0]});
                if (step_ready) begin
                    hs_cnt++;
                    if (exp_q[0][0] && !clear) due_n = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
        end
        if (cmd_valid && cmd_ready) begin
            acc_cnt++;
            model_push(cmd_num_row, cmd_num_col, cmd_num_k, cmd_info);
        end
        if (clear) begin
            exp_q.delete();
            due_n = 1'b0;
        end
        done_due = due_n;
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input int nr, input int nc, input int nk, input logic [15:0] inf);
        cmd_valid   = 1'b1;
        cmd_num_row = 8'(nr);
        cmd_num_col = 8'(nc);
        cmd_num_k   = 8'(nk);
        cmd_info    = inf;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && (exp_q.size() != 0 || busy); i++) cycle();
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        cycle();
        cycle();
    endtask

    initial begin
        int hs0, dn0, acc0;
        logic [15:0] pat;
        rst = 1'b1; clear = 1'b0; cmd_valid = 1'b0; step_ready = 1'b0;
        cmd_num_row = '0; cmd_num_col = '0; cmd_num_k = '0; cmd_info = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_outputs", {21'd0, step_info, step_row, step_col, step_k, step_first_k,
                            step_last_k, step_last}, 64'd0);
        chk("rst_flags", {61'd0, step_valid, busy, done}, 64'd0);

        // Basic 2x2x2 walk with latency check.
        step_ready = 1'b1;
        hs0 = hs_cnt; dn0 = done_cnt;
        push_cmd(2, 2, 2, 16'hA5A5);
        chk("lat_bubble", {62'd0, step_valid, busy}, 64'd1);
        cycle();
        chk("lat_first", {63'd0, step_valid}, 64'd1);
        drain(40);
        chk("t1_steps", 64'(hs_cnt - hs0), 64'd8);
        chk("t1_done", 64'(done_cnt - dn0), 64'd1);

        // Stalled 1x1x3 command.
        step_ready = 1'b0;
        hs0 = hs_cnt; dn0 = done_cnt;
        push_cmd(1, 1, 3, 16'h1234);
        cycle();
        pat = 16'b101001;
        for (int i = 0; i < 6; i++) begin
            step_ready = pat[i];
            cycle();
        end
        step_ready = 1'b1;
        drain(20);
        chk("t2_steps", 64'(hs_cnt - hs0), 64'd3);
        chk("t2_done", 64'(done_cnt - dn0), 64'd1);

        // Back-to-back pushes with downstream blocked.
        step_ready = 1'b0;
        hs0 = hs_cnt; dn0 = done_cnt; acc0 = acc_cnt;
        for (int i = 0; i < 7; i++) begin
            cmd_valid = 1'b1; cmd_num_row = 8'd1; cmd_num_col = 8'd1 + 8'(i % 2);
            cmd_num_k = 8'd2; cmd_info = 16'(16'h100 + i);
            cycle();
        end
        cmd_valid = 1'b0;
        chk("t3_accepted", 64'(acc_cnt - acc0), 64'd5);
        chk("t3_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        step_ready = 1'b1;
        drain(100);
        chk("t3_done", 64'(done_cnt - dn0), 64'd5);

        // Zero-count command is dropped, then a single-step command.
        hs0 = hs_cnt; dn0 = done_cnt;
        push_cmd(0, 3, 3, 16'hDEAD);
        push_cmd(1, 1, 1, 16'hBEEF);
        drain(20);
        chk("t4_steps", 64'(hs_cnt - hs0), 64'd1);
        chk("t4_done", 64'(done_cnt - dn0), 64'd2);

        // Clear in the middle of a 4x4x4 command.
        hs0 = hs_cnt;
        push_cmd(4, 4, 4, 16'h0F0F);
        for (int i = 0; i < 100 && (hs_cnt - hs0) < 10; i++) cycle();
        chk("t5_hs_before_clear", 64'(hs_cnt - hs0), 64'd10);
        dn0 = done_cnt;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("t5_after_clear", {61'd0, step_valid, busy, done}, 64'd0);
        cycle();
        chk("t5_no_done", {63'd0, done}, 64'd0);
        chk("t5_done_cnt", 64'(done_cnt - dn0), 64'd0);
        hs0 = hs_cnt; dn0 = done_cnt;
        push_cmd(1, 1, 1, 16'h7777);
        drain(20);
        chk("t5_restart_steps", 64'(hs_cnt - hs0), 64'd1);
        chk("t5_restart_done", 64'(done_cnt - dn0), 64'd1);

        // Randomized traffic with zero counts and random back-pressure.
        dn0 = done_cnt; acc0 = acc_cnt;
        for (int i = 0; i < 400; i++) begin
            cmd_valid   = ($urandom_range(0, 2) == 0);
            cmd_num_row = 8'($urandom_range(0, 3));
            cmd_num_col = 8'($urandom_range(0, 3));
            cmd_num_k   = 8'($urandom_range(0, 3));
            cmd_info    = 16'($urandom);
            step_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        cmd_valid = 1'b0;
        step_ready = 1'b1;
        drain(2000);
        chk("rand_done_total", 64'(done_cnt - dn0), 64'(acc_cnt - acc0));
        chk("rand_idle", {62'd0, busy, step_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
